// File: rtl/sd_cmd_phy.sv
// sd_cmd_phy: bit-level SD command line engine.
// Serialises a 48-bit command frame (start, direction, index, argument, CRC7, end)
// on the CMD pin, then optionally receives a 48-bit or 136-bit response with
// Ncr timeout detection and an optional CRC7/end-bit check.
//
// Ports:
//   clk_i, rst_i       system clock, synchronous active-high reset
//   clk_en_i           one-cycle strobe per SD clock period (bit slot)
//   start_i            command request, accepted only while idle
//   cmd_index_i[5:0]   command index
//   cmd_arg_i[31:0]    command argument
//   resp_type_i[1:0]   00 none, 01 48-bit, 10 136-bit, 11 48-bit
//   busy_o, done_o     in-progress flag and one-cycle completion pulse
//   resp_o[127:0]      raw response frame
//   timeout_o          no response start bit within TIMEOUT ticks
//   crc_err_o          response CRC7 mismatch or end bit low
//   cmd_i, cmd_o, cmd_t CMD pin input, output value, tristate (1 = released)
//
// Build option: define SD_CMD_CRC_CHECK_EN to build the response CRC7/end-bit
// check; when undefined crc_err_o is tied low. Transmit CRC is always built.
module sd_cmd_phy #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clk_en_i,
    input  logic         start_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] resp_o,
    output logic         timeout_o,
    output logic         crc_err_o,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_t
);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned RESP_W   = 128;
    localparam logic [5:0]  TX_TOP   = 6'd47;
    // Index of the first bit after the start bit
    localparam logic [7:0]  RX_TOP_S = 8'd46;
    localparam logic [7:0]  RX_TOP_L = 8'd134;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_NCR,
        S_RX,
        S_NCC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [39:0]         tx_sr_q, tx_sr_d;
    logic [6:0]          tx_crc_q, tx_crc_d;
    logic                none_q, none_d;
    logic                long_q, long_d;
    logic [CNT_W-1:0]    ncr_cnt_q, ncr_cnt_d;
    logic [2:0]          ncc_cnt_q, ncc_cnt_d;
    logic [7:0]          rx_cnt_q, rx_cnt_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic                timeout_q, timeout_d;
    logic                cmd_o_q, cmd_o_d;
    logic                cmd_t_q, cmd_t_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0]          rx_crc_q, rx_crc_d;
    logic                crc_err_q, crc_err_d;
`endif

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB first
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Next-state and datapath update; everything advances only on clk_en_i
    // except start capture and the one-cycle DONE exit.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        tx_crc_d  = tx_crc_q;
        none_d    = none_q;
        long_d    = long_q;
        ncr_cnt_d = ncr_cnt_q;
        ncc_cnt_d = ncc_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        resp_d    = resp_q;
        timeout_d = timeout_q;
        cmd_o_d   = cmd_o_q;
        cmd_t_d   = cmd_t_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
        rx_crc_d  = rx_crc_q;
        crc_err_d = crc_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                cmd_o_d = 1'b1;
                cmd_t_d = 1'b1;
                if (start_i) begin
                    tx_sr_d   = {2'b01, cmd_index_i, cmd_arg_i};
                    tx_crc_d  = 7'h00;
                    bit_cnt_d = TX_TOP;
                    none_d    = (resp_type_i == 2'b00);
                    long_d    = (resp_type_i == 2'b10);
                    resp_d    = '0;
                    timeout_d = 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
                    crc_err_d = 1'b0;
`endif
                    busy_d    = 1'b1;
                    state_d   = S_TX;
                end
            end

            S_TX: begin
                if (clk_en_i) begin
                    cmd_t_d = 1'b0;
                    if (bit_cnt_q >= 6'd8) begin
                        // Header and argument bits feed the CRC as they go out
                        cmd_o_d  = tx_sr_q[39];
                        tx_sr_d  = {tx_sr_q[38:0], 1'b0};
                        tx_crc_d = crc7_step(tx_crc_q, tx_sr_q[39]);
                    end else if (bit_cnt_q != 6'd0) begin
                        cmd_o_d = tx_crc_q[3'(bit_cnt_q - 6'd1)];
                    end else begin
                        cmd_o_d = 1'b1;
                    end
                    if (bit_cnt_q == 6'd0) begin
                        ncr_cnt_d = '0;
                        ncc_cnt_d = 3'd0;
                        state_d   = none_q ? S_NCC : S_NCR;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 6'd1;
                    end
                end
            end

            S_NCR: begin
                if (clk_en_i) begin
                    cmd_o_d = 1'b1;
                    cmd_t_d = 1'b1;
                    if (!cmd_i) begin
                        rx_cnt_d = long_q ? RX_TOP_L : RX_TOP_S;
`ifdef SD_CMD_CRC_CHECK_EN
                        rx_crc_d = 7'h00;
`endif
                        state_d  = S_RX;
                    end else if (ncr_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        ncc_cnt_d = 3'd0;
                        state_d   = S_NCC;
                    end else begin
                        ncr_cnt_d = ncr_cnt_q + CNT_W'(1);
                    end
                end
            end

            S_RX: begin
                if (clk_en_i) begin
                    // rx_cnt_q is the frame index of the bit being sampled
                    resp_d = {resp_q[RESP_W-2:0], cmd_i};
`ifdef SD_CMD_CRC_CHECK_EN
                    if (rx_cnt_q >= 8'd8 && rx_cnt_q <= 8'd127) begin
                        rx_crc_d = crc7_step(rx_crc_q, cmd_i);
                    end else if (rx_cnt_q != 8'd0) begin
                        if (cmd_i != rx_crc_q[3'(rx_cnt_q - 8'd1)]) begin
                            crc_err_d = 1'b1;
                        end
                    end else if (!cmd_i) begin
                        crc_err_d = 1'b1;
                    end
`endif
                    if (rx_cnt_q == 8'd0) begin
                        ncc_cnt_d = 3'd0;
                        state_d   = S_NCC;
                    end else begin
                        rx_cnt_d = rx_cnt_q - 8'd1;
                    end
                end
            end

            S_NCC: begin
                if (clk_en_i) begin
                    cmd_o_d = 1'b1;
                    cmd_t_d = 1'b1;
                    if (ncc_cnt_q == 3'd7) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        ncc_cnt_d = ncc_cnt_q + 3'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 6'd0;
            tx_sr_q   <= 40'd0;
            tx_crc_q  <= 7'h00;
            none_q    <= 1'b0;
            long_q    <= 1'b0;
            ncr_cnt_q <= '0;
            ncc_cnt_q <= 3'd0;
            rx_cnt_q  <= 8'd0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
            cmd_o_q   <= 1'b1;
            cmd_t_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
            rx_crc_q  <= 7'h00;
            crc_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            tx_crc_q  <= tx_crc_d;
            none_q    <= none_d;
            long_q    <= long_d;
            ncr_cnt_q <= ncr_cnt_d;
            ncc_cnt_q <= ncc_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
            cmd_o_q   <= cmd_o_d;
            cmd_t_q   <= cmd_t_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SD_CMD_CRC_CHECK_EN
            rx_crc_q  <= rx_crc_d;
            crc_err_q <= crc_err_d;
`endif
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign resp_o    = resp_q;
    assign timeout_o = timeout_q;
    assign cmd_o     = cmd_o_q;
    assign cmd_t     = cmd_t_q;
`ifdef SD_CMD_CRC_CHECK_EN
    assign crc_err_o = crc_err_q;
`else
    assign crc_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Self-checking bench for sd_cmd_phy: random clock-enable pattern, a card model
// that drives response frames, and a polynomial-division CRC7 reference.
module tb_sd_cmd_phy;

    localparam int unsigned TIMEOUT = 64;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         clk_en_i = 1'b0;
    logic         start_i = 1'b0;
    logic [5:0]   cmd_index_i = 6'd0;
    logic [31:0]  cmd_arg_i = 32'd0;
    logic [1:0]   resp_type_i = 2'd0;
    logic         busy_o;
    logic         done_o;
    logic [127:0] resp_o;
    logic         timeout_o;
    logic         crc_err_o;
    logic         cmd_i = 1'b1;
    logic         cmd_o;
    logic         cmd_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [47:0] last_tx;

    sd_cmd_phy #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clk_en_i    (clk_en_i),
        .start_i     (start_i),
        .cmd_index_i (cmd_index_i),
        .cmd_arg_i   (cmd_arg_i),
        .resp_type_i (resp_type_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .resp_o      (resp_o),
        .timeout_o   (timeout_o),
        .crc_err_o   (crc_err_o),
        .cmd_i       (cmd_i),
        .cmd_o       (cmd_o),
        .cmd_t       (cmd_t)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [119:0] msg, input int n);
        int unsigned r;
        r = 0;
        for (int i = n - 1; i >= 0; i--) begin
            r = (r << 1) | 32'(msg[i]);
            if ((r & 32'h80) != 0) r = r ^ 32'h89;
        end
        for (int i = 0; i < 7; i++) begin
            r = r << 1;
            if ((r & 32'h80) != 0) r = r ^ 32'h89;
        end
        return 7'(r);
    endfunction

    // Card-side line value for bit slot u (slots counted from the capture cycle)
    function automatic logic line_bit(input int u, input int dly, input int len,
                                      input logic [135:0] fr);
        int s;
        s = 48 + dly + 1;
        if (len > 0 && u >= s && u < s + len) return fr[len - 1 - (u - s)];
        return 1'b1;
    endfunction

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] rt, input int dly, input int len,
                           input logic [135:0] rframe, input bit inj);
        logic [47:0]  exp_tx, got_tx;
        logic [135:0] exp_resp;
        logic         exp_to, exp_err, en, seen;
        int           t, done_t, exp_done, tx_t_bad, frz_bad;
        logic         pc_o, pc_t;

        exp_tx   = {2'b01, idx, arg, crc7_ref({80'd0, 2'b01, idx, arg}, 40), 1'b1};
        exp_to   = (rt != 2'b00) && (len == 0);
        exp_done = (len > 0) ? (48 + dly + len + 8) : ((rt == 2'b00) ? 56 : 48 + TIMEOUT + 8);
        exp_resp = '0;
        exp_err  = 1'b0;
        if (len == 48) exp_resp = {88'd0, rframe[47:0]};
        if (len == 136) exp_resp = {8'd0, rframe[127:0]};
`ifdef SD_CMD_CRC_CHECK_EN
        if (len == 48)
            exp_err = (crc7_ref({80'd0, rframe[47:8]}, 40) != rframe[7:1]) || !rframe[0];
        if (len == 136)
            exp_err = (crc7_ref(rframe[127:8], 120) != rframe[7:1]) || !rframe[0];
`endif

        start_i     = 1'b1;
        cmd_index_i = idx;
        cmd_arg_i   = arg;
        resp_type_i = rt;
        clk_en_i    = 1'($urandom_range(0, 1));
        cmd_i       = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check({tag, "_busy"}, 136'(busy_o), 136'(1));

        t = 0; done_t = -1; seen = 1'b0; tx_t_bad = 0; frz_bad = 0; got_tx = '0;
        pc_o = cmd_o; pc_t = cmd_t;
        for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
            en       = ($urandom_range(0, 2) != 0);
            clk_en_i = en;
            cmd_i    = en ? line_bit(t + 1, dly, len, rframe) : 1'($urandom_range(0, 1));
            if (inj && cyc == 30) begin
                start_i     = 1'b1;
                cmd_index_i = ~idx;
                cmd_arg_i   = ~arg;
                resp_type_i = 2'b00;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i); #1;
            if (en) t++;
            if (en && t <= 48) begin
                got_tx = {got_tx[46:0], cmd_o};
                if (cmd_t !== 1'b0) tx_t_bad++;
            end
            if (en && t == 49) check({tag, "_release"}, 136'(cmd_t), 136'(1));
            if (!en && (cmd_o !== pc_o || cmd_t !== pc_t)) frz_bad++;
            pc_o = cmd_o;
            pc_t = cmd_t;
            if (done_o === 1'b1) begin
                seen   = 1'b1;
                done_t = t;
                check({tag, "_busy_at_done"}, 136'(busy_o), 136'(0));
            end
        end
        start_i = 1'b0;
        last_tx = got_tx;

        check({tag, "_done_seen"}, 136'(seen), 136'(1));
        check({tag, "_done_tick"}, 136'(done_t), 136'(exp_done));
        check({tag, "_tx_frame"}, 136'(got_tx), 136'(exp_tx));
        check({tag, "_tx_drive"}, 136'(tx_t_bad), 136'(0));
        check({tag, "_freeze"}, 136'(frz_bad), 136'(0));
        check({tag, "_resp"}, 136'(resp_o), exp_resp);
        check({tag, "_timeout"}, 136'(timeout_o), 136'(exp_to));
        check({tag, "_crc_err"}, 136'(crc_err_o), 136'(exp_err));

        clk_en_i = 1'b1;
        cmd_i    = 1'b1;
        @(posedge clk_i); #1;
        check({tag, "_done_pulse"}, 136'(done_o), 136'(0));
        for (int k = 0; k < 5; k++) begin
            clk_en_i = 1'($urandom_range(0, 1));
            cmd_i    = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
        end
        cmd_i = 1'b1;
        check({tag, "_resp_hold"}, 136'(resp_o), exp_resp);
        check({tag, "_idle_busy"}, 136'(busy_o), 136'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [135:0] fr;
        logic [39:0]  hi;
        logic [119:0] body;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rt;
        int           dly, len, t, ndone;
        logic         en;

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_cmd_o", 136'(cmd_o), 136'(1));
        check("rst_cmd_t", 136'(cmd_t), 136'(1));
        check("rst_busy", 136'(busy_o), 136'(0));
        check("rst_done", 136'(done_o), 136'(0));
        check("rst_resp", 136'(resp_o), 136'(0));
        check("rst_flags", 136'({timeout_o, crc_err_o}), 136'(0));

        // CMD0, no response
        run_cmd("cmd0", 6'd0, 32'd0, 2'b00, 0, 0, '0, 1'b0);
        check("cmd0_wire", 136'(last_tx), 136'(48'h40_0000_0000_95));

        // CMD8 with a valid short response after 5 slots
        fr = {88'd0, 48'h08_0000_01AA_13};
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 2'b01, 5, 48, fr, 1'b0);
        check("cmd8_wire", 136'(last_tx), 136'(48'h48_0000_01AA_87));

        // Same with reply bit 20 corrupted
        fr[20] = ~fr[20];
        run_cmd("cmd8_bad", 6'd8, 32'h0000_01AA, 2'b01, 5, 48, fr, 1'b0);

        // No card answer
        run_cmd("tmo", 6'd55, 32'h1234_5678, 2'b01, 0, 0, '0, 1'b0);

        // CMD2 with a 136-bit reply; a start pulse is injected while busy
        body = {$urandom, $urandom, $urandom, 24'($urandom)};
        fr   = {8'h3F, body, crc7_ref(body, 120), 1'b1};
        run_cmd("cmd2", 6'd2, 32'd0, 2'b10, 3, 136, fr, 1'b1);

        // Random commands
        for (int i = 0; i < 6; i++) begin
            idx = 6'($urandom);
            arg = $urandom;
            rt  = 2'($urandom);
            dly = $urandom_range(1, 20);
            if (rt == 2'b00) len = 0;
            else if ($urandom_range(0, 3) == 0) len = 0;
            else len = (rt == 2'b10) ? 136 : 48;
            fr = '0;
            if (len == 48) begin
                hi = {1'b0, 7'($urandom), $urandom};
                fr = {88'd0, hi, crc7_ref({80'd0, hi}, 40), 1'b1};
                if ($urandom_range(0, 1) == 1) begin
                    t = $urandom_range(0, 46);
                    fr[t] = ~fr[t];
                end
            end else if (len == 136) begin
                body = {$urandom, $urandom, $urandom, 24'($urandom)};
                fr   = {8'h3F, body, crc7_ref(body, 120), 1'b1};
                if ($urandom_range(0, 1) == 1) begin
                    t = $urandom_range(0, 127);
                    fr[t] = ~fr[t];
                end
            end
            run_cmd("rnd", idx, arg, rt, dly, len, fr, 1'b0);
        end

        // Reset in the middle of transmission
        start_i     = 1'b1;
        cmd_index_i = 6'd17;
        cmd_arg_i   = $urandom;
        resp_type_i = 2'b01;
        clk_en_i    = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        t = 0;
        for (int cyc = 0; cyc < 400 && t < 20; cyc++) begin
            en       = 1'($urandom_range(0, 1));
            clk_en_i = en;
            @(posedge clk_i); #1;
            if (en) t++;
        end
        check("midtx_busy", 136'(busy_o), 136'(1));
        check("midtx_drive", 136'(cmd_t), 136'(0));
        rst_i    = 1'b1;
        clk_en_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("midrst_cmd_t", 136'(cmd_t), 136'(1));
        check("midrst_cmd_o", 136'(cmd_o), 136'(1));
        check("midrst_busy", 136'(busy_o), 136'(0));
        ndone = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            clk_en_i = 1'($urandom_range(0, 1));
            @(posedge clk_i); #1;
            if (done_o === 1'b1) ndone++;
        end
        check("midrst_no_done", 136'(ndone), 136'(0));
        check("midrst_idle", 136'({busy_o, cmd_t}), 136'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_phy.md
# sd_cmd_phy

Bit-level SD command-line engine that sits directly downstream of the SD host controller's register file and drives the CMD pin pair on the FPGA board. On a start pulse it serialises a 48-bit command frame with generated CRC7. It then optionally receives a 48-bit or 136-bit response, checking for timeout and CRC errors. It hands the raw response back to the controller's registers.

## Interface
- TIMEOUT, 64: maximum SD clock ticks (Ncr) to wait for a response start bit.
- clk_i  in  1  system clock; all logic runs on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clk_en_i  in  1  one-cycle strobe per SD clock period; marks each bit slot for driving and sampling.
- start_i  in  1  command request pulse; accepted only while idle.
- cmd_index_i  in  6  command index.
- cmd_arg_i  in  32  command argument.
- resp_type_i  in  2  response type: 00 none, 01 48-bit, 10 136-bit, 11 treated as 48-bit.
- busy_o  out  1  high while a command is in progress.
- done_o  out  1  one-clk_i completion pulse.
- resp_o  out  128  raw response frame.
- timeout_o  out  1  no response start bit seen within TIMEOUT ticks.
- crc_err_o  out  1  response CRC7 mismatch or end bit equal to 0.
- cmd_i  in  1  CMD pin input.
- cmd_o  out  1  CMD pin output value.
- cmd_t  out  1  CMD pin tristate control; 1 = released/input.

## Operation
- Frame is transmitted MSB first: 0, 1, index[5:0], arg[31:0], crc7[6:0], 1.
- CRC7 uses polynomial x^7+x^3+1 with zero initial value, computed over the first 40 bits.
- **IDLE**
  - cmd_o=1, cmd_t=1.
  - start_i latches index, arg and type; clears resp_o and both flags; goes to TX.
  - start_i is ignored in all other states.
- **TX**
  - cmd_t=0.
  - Bit counter runs from 47 down to 0, one bit per clk_en_i.
  - After the end bit: cmd_t=1. Type 00 goes to NCC; all other types go to NCR.
- **NCR**
  - The line is sampled on each clk_en_i.
  - cmd_i=0 is the start bit: go to RX.
  - After TIMEOUT ticks without a start bit: timeout_o=1, go to NCC.
- **RX**
  - Shifts in the remaining 47 bits (48-bit type) or 135 bits (136-bit type).
  - 48-bit: resp_o[47:0] = full frame including the start bit; resp_o[127:48]=0. CRC is checked over bits 47..8 against bits 7..1.
  - 136-bit: resp_o = frame bits 127..0. CRC is checked over bits 127..8 against bits 7..1.
  - Bit 0 equal to 0 sets crc_err_o.
  - Then go to NCC.
- **NCC**
  - Waits 8 clk_en_i ticks with cmd_o=1, cmd_t=1, then goes to DONE.
- **DONE**
  - done_o=1 for one clk_i cycle, busy_o=0 in the same cycle, then IDLE.
- resp_o, timeout_o and crc_err_o hold their values until the next accepted start_i.

## Timing
- Reset values: cmd_o=1, cmd_t=1, busy_o=0, done_o=0, resp_o=0, timeout_o=0, crc_err_o=0; state IDLE.
- **Start and busy**
  - busy_o rises on the clk_i edge that captures start_i.
  - The first frame bit is driven on the first clk_en_i strictly after the capture cycle, even if start_i and clk_en_i coincide.
- **Bit timing**
  - Each bit is held for one full enable period.
  - cmd_o and cmd_t change only on clk_en_i cycles.
  - cmd_i is sampled only on clk_en_i cycles.
- **Latency, no response**: 48 + 8 ticks, then done_o.
- **Latency, 48-bit response**: 48 + Ncr + 48 + 8 ticks.
- **Latency, timeout**: 48 + TIMEOUT + 8 ticks.
- clk_en_i held low freezes all state and outputs indefinitely.
- rst_i asserted mid-command returns to the reset values on the next edge (line released); no done_o pulse is generated.
- The TIMEOUT counter must hold values up to TIMEOUT without wrap: width is clog2(TIMEOUT+1).

## Configuration
- SD_CMD_CRC_CHECK_EN defined: the response CRC7 and end-bit check is built, and crc_err_o is driven as described above.
- SD_CMD_CRC_CHECK_EN undefined: the receive CRC logic is removed and crc_err_o is tied to 0.
- Transmit CRC generation is always present, with or without the macro.

## Test plan
- CMD0, arg 0, type 00 -> CMD line carries 0x40_00000000_95, cmd_t=0 for 48 ticks; done_o pulses after 8 more ticks; timeout_o=0.
- CMD8, arg 0x000001AA, type 01, card replies 0x08_000001AA_13 after 5 ticks -> transmitted CRC byte 0x87; resp_o=0x08000001AA13; crc_err_o=0.
- Same as the previous scenario but reply bit 20 flipped -> crc_err_o=1 (0 when the macro is undefined); resp_o holds the corrupted frame.
- Type 01, cmd_i held 1 -> timeout_o=1; done_o exactly TIMEOUT+8 ticks after the end bit.
- CMD2, type 10, 136-bit reply with valid CRC -> resp_o equals frame bits 127..0; crc_err_o=0.
- rst_i pulsed mid-TX and start_i pulsed while busy -> cmd_t=1 and busy_o=0 on the next edge after reset; start_i while busy has no effect.
